// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and
// datapath select values.
package ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned WB_SRC_W = 2;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_HALT  = 1;
  localparam int unsigned OP_LOAD  = 2;
  localparam int unsigned OP_STORE = 3;
  localparam int unsigned OP_CLEAR = 4;
  localparam int unsigned OP_SKIP  = 5;
  localparam int unsigned OP_JUMP  = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [PC_SRC_W-1:0] PC_SRC_INC  = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP = 2'd1;

  localparam logic [WB_SRC_W-1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [WB_SRC_W-1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [WB_SRC_W-1:0] WB_SRC_ZERO = 2'd2;

  localparam int unsigned ALU_OP_ADD = 0;

endpackage

// File: rtl/ctrl_watchdog.sv
// Memory-handshake watchdog: counts stalled request cycles and flags expiry in
// the cycle the count would reach TIMEOUT. TIMEOUT=0 disables it.
module ctrl_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready response in the final cycle drops en, so completion wins over expiry.
  assign expired = (TIMEOUT > 0) && en && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: drives datapath enables/selects over a
// shared handshaked memory port, with illegal-opcode and timeout trapping.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALUOPW  = 2,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sel,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              reg_write,
  output logic              reg_dst,
  output logic [1:0]        wb_src,
  output logic              alu_src,
  output logic [ALUOPW-1:0] alu_op,
  output logic              halted,
  output logic              illegal,
  output logic              bus_err,
  output logic [CNTW-1:0]   retired,
  output logic [2:0]        state
);

  localparam logic [OPW-1:0] OPC_ADD   = OPW'(OP_ADD);
  localparam logic [OPW-1:0] OPC_HALT  = OPW'(OP_HALT);
  localparam logic [OPW-1:0] OPC_LOAD  = OPW'(OP_LOAD);
  localparam logic [OPW-1:0] OPC_STORE = OPW'(OP_STORE);
  localparam logic [OPW-1:0] OPC_CLEAR = OPW'(OP_CLEAR);
  localparam logic [OPW-1:0] OPC_SKIP  = OPW'(OP_SKIP);
  localparam logic [OPW-1:0] OPC_JUMP  = OPW'(OP_JUMP);

  state_e            state_q, state_d;
  logic              illegal_q, bus_err_q;
  logic [CNTW-1:0]   retired_q;
  logic              retire_c, trap_ill_c, timeout_c, wd_clr_c, wd_en_c;

  ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr_c),
    .en      (wd_en_c),
    .expired (timeout_c)
  );

  assign wd_en_c  = mem_req && !mem_ready;
  assign wd_clr_c = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trap_ill_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (timeout_c)      state_d = ST_HALT;
        else if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OPC_ADD, OPC_LOAD, OPC_STORE: state_d = ST_EXEC;
          OPC_CLEAR:                    state_d = ST_WB;
          OPC_SKIP, OPC_JUMP:           state_d = ST_FETCH;
          OPC_HALT:                     state_d = ST_HALT;
          default: begin
            state_d    = ST_HALT;
            trap_ill_c = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        if (opcode == OPC_ADD)                               state_d = ST_WB;
        else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) state_d = ST_MEM;
        else                                                  state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (timeout_c)      state_d = ST_HALT;
        else if (mem_ready) state_d = (opcode == OPC_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
    retire_c = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
               ((state_q == ST_DECODE) && (opcode == OPC_HALT));
  end

  // Outputs decode from state/opcode; held low while reset is asserted.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_INC;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_src    = WB_SRC_ALU;
    alu_src   = 1'b0;
    alu_op    = '0;
    halted    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_DECODE: begin
          if (opcode == OPC_SKIP) begin
            pc_write = zero;
          end else if (opcode == OPC_JUMP) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end
        end
        ST_EXEC: begin
          alu_op  = ALUOPW'(ALU_OP_ADD);
          alu_src = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (opcode == OPC_STORE);
        end
        ST_WB: begin
          reg_write = 1'b1;
          if (opcode == OPC_LOAD) begin
            wb_src = WB_SRC_MEM;
          end else begin
            reg_dst = 1'b1;
            wb_src  = (opcode == OPC_CLEAR) ? WB_SRC_ZERO : WB_SRC_ALU;
          end
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky traps and saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (trap_ill_c) illegal_q <= 1'b1;
      if (timeout_c)  bus_err_q <= 1'b1;
      if (retire_c && (retired_q != '1)) retired_q <= retired_q + CNTW'(1);
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle sequences built
// from the ISA timing rules, directed cases followed by random instructions.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned RMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, mem_sel, ir_write, pc_write;
  logic [1:0]    pc_src, wb_src, alu_op;
  logic          reg_write, reg_dst, alu_src, halted, illegal, bus_err;
  logic [CW-1:0] retired;
  logic [2:0]    state;

  multicycle_ctrl #(.OPW(4), .ALUOPW(2), .TIMEOUT(TO), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_src(wb_src), .alu_src(alu_src), .alu_op(alu_op), .halted(halted),
    .illegal(illegal), .bus_err(bus_err), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, sel, irw, pcw;
    logic [1:0] pcs;
    logic       rw, rd;
    logic [1:0] wbs;
    logic       asrc;
    logic [1:0] aop;
    logic       hlt;
  } outs_t;

  typedef struct {
    outs_t o;
    logic  rdy, z, ret, ill, berr;
  } cyc_t;

  cyc_t        q[$];
  int          errs = 0;
  int          checks = 0;
  int unsigned ret_m = 0;
  logic        ill_m = 1'b0, berr_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic outs_t obs();
    outs_t o;
    o.st = state; o.req = mem_req; o.we = mem_we; o.sel = mem_sel;
    o.irw = ir_write; o.pcw = pc_write; o.pcs = pc_src; o.rw = reg_write;
    o.rd = reg_dst; o.wbs = wb_src; o.asrc = alu_src; o.aop = alu_op; o.hlt = halted;
    return o;
  endfunction

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c.o = '0; c.o.st = st;
    c.rdy = 1'($urandom); c.z = 1'($urandom);
    c.ret = 1'b0; c.ill = 1'b0; c.berr = 1'b0;
    return c;
  endfunction

  task automatic push_halt(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(3'(ST_HALT)); c.o.hlt = 1'b1; q.push_back(c);
    end
  endtask

  // One memory access: waits stall cycles then a ready cycle, unless the watchdog fires first.
  task automatic push_access(input logic sel, input logic we, input int waits, output logic aborted);
    cyc_t c;
    aborted = 1'b0;
    for (int k = 0; k < waits; k++) begin
      c = blank(sel ? 3'(ST_MEM) : 3'(ST_FETCH));
      c.o.req = 1'b1; c.o.sel = sel; c.o.we = we; c.rdy = 1'b0;
      if (k == int'(TO) - 1) begin
        c.berr = 1'b1; q.push_back(c); aborted = 1'b1;
        return;
      end
      q.push_back(c);
    end
    c = blank(sel ? 3'(ST_MEM) : 3'(ST_FETCH));
    c.o.req = 1'b1; c.o.sel = sel; c.o.we = we; c.rdy = 1'b1;
    if (!sel) begin c.o.irw = 1'b1; c.o.pcw = 1'b1; end
    q.push_back(c);
  endtask

  task automatic push_wb(input int op);
    cyc_t c;
    c = blank(3'(ST_WB)); c.o.rw = 1'b1; c.o.rd = (op != OP_LOAD);
    c.o.wbs = (op == OP_LOAD) ? 2'd1 : (op == OP_CLEAR) ? 2'd2 : 2'd0;
    c.ret = 1'b1; q.push_back(c);
  endtask

  // Expected cycle list for one instruction; stop=1 when it ends in the halt state.
  task automatic build(input int op, input logic z, input int wf, input int wm, output logic stop);
    cyc_t c;
    logic ab;
    stop = 1'b0;
    push_access(1'b0, 1'b0, wf, ab);
    if (ab) begin push_halt(3); stop = 1'b1; return; end
    c = blank(3'(ST_DECODE)); c.z = z;
    case (op)
      OP_ADD, OP_LOAD, OP_STORE, OP_CLEAR: ;
      OP_SKIP: begin c.o.pcw = z; c.ret = 1'b1; end
      OP_JUMP: begin c.o.pcw = 1'b1; c.o.pcs = 2'd1; c.ret = 1'b1; end
      OP_HALT: c.ret = 1'b1;
      default: c.ill = 1'b1;
    endcase
    q.push_back(c);
    if (op == OP_HALT || op > OP_JUMP) begin push_halt(3); stop = 1'b1; return; end
    if (op == OP_SKIP || op == OP_JUMP) return;
    if (op == OP_CLEAR) begin push_wb(op); return; end
    c = blank(3'(ST_EXEC)); c.o.asrc = (op != OP_ADD); q.push_back(c);
    if (op == OP_ADD) begin push_wb(op); return; end
    push_access(1'b1, op == OP_STORE, wm, ab);
    if (ab) begin push_halt(3); stop = 1'b1; return; end
    if (op == OP_STORE) q[q.size()-1].ret = 1'b1;
    else push_wb(op);
  endtask

  // Each step starts at a falling edge: drive, check, then advance the model.
  task automatic run(input int limit);
    int n = 0;
    cyc_t c;
    while (q.size() > 0 && n < limit) begin
      c = q.pop_front();
      zero = c.z; mem_ready = c.rdy;
      #1;
      chk("outs", 64'(obs()), 64'(c.o));
      chk("retired", 64'(retired), 64'(ret_m));
      chk("illegal", 64'(illegal), 64'(ill_m));
      chk("bus_err", 64'(bus_err), 64'(berr_m));
      if (c.ret && ret_m < RMAX) ret_m++;
      if (c.ill) ill_m = 1'b1;
      if (c.berr) berr_m = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'($urandom);
    #1 chk("rst_req_drop", 64'(mem_req), 64'(0));
    @(posedge clk); #1;
    chk("rst_outs", 64'(obs()), 64'({3'(ST_FETCH), 15'd0}));
    chk("rst_retired", 64'(retired), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_bus_err", 64'(bus_err), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    q.delete(); ret_m = 0; ill_m = 1'b0; berr_m = 1'b0;
  endtask

  task automatic instr(input int op, input logic z, input int wf, input int wm, output logic stop);
    opcode = 4'(op);
    build(op, z, wf, wm, stop);
    run(1000);
  endtask

  initial begin
    logic stop;
    int   op, r, wf, wm;
    @(negedge clk);
    do_reset();

    instr(OP_ADD, 1'b0, 0, 0, stop);
    chk("add_retired", 64'(retired), 64'(1));
    instr(OP_LOAD, 1'b0, 2, 2, stop);
    chk("load_retired", 64'(retired), 64'(2));
    instr(OP_STORE, 1'b0, 0, 0, stop);
    instr(OP_SKIP, 1'b1, 0, 0, stop);
    instr(OP_SKIP, 1'b0, 1, 0, stop);
    instr(OP_JUMP, 1'b0, 0, 0, stop);
    instr(OP_CLEAR, 1'b0, 1, 0, stop);
    chk("mix_retired", 64'(retired), 64'(7));

    instr(9, 1'b0, 0, 0, stop);
    push_halt(17); run(1000);
    chk("ill_retired", 64'(retired), 64'(7));
    do_reset();

    instr(OP_HALT, 1'b0, 0, 0, stop);
    chk("halt_retired", 64'(retired), 64'(1));
    do_reset();

    instr(OP_ADD, 1'b0, 4, 0, stop);
    chk("to_fetch_berr", 64'(bus_err), 64'(1));
    do_reset();
    instr(OP_ADD, 1'b0, 3, 0, stop);
    chk("to_edge_ok", 64'(bus_err), 64'(0));
    instr(OP_LOAD, 1'b0, 0, 5, stop);
    do_reset();

    for (int i = 0; i < 17; i++) instr(OP_JUMP, 1'b0, 0, 0, stop);
    chk("retired_sat", 64'(retired), 64'(RMAX));
    do_reset();

    opcode = 4'(OP_LOAD);
    build(OP_LOAD, 1'b0, 0, 2, stop);
    run(4);
    do_reset();
    instr(OP_STORE, 1'b0, 0, 1, stop);

    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 15));
      op = (r < 12) ? (r % 7) : r;
      wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
      wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
      instr(op, 1'($urandom), wf, wm, stop);
      if (stop) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle control unit for the project CPU, replacing the single-cycle combinational decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states over one shared handshaked memory port. Drives all datapath enables and selects for the add/halt/load/store/clear/skip/jump ISA. Also provides illegal-opcode and memory-timeout trapping and a retired-instruction counter.

## Interface
- OPW, 4, opcode width (≥3)
- ALUOPW, 2, alu_op width
- TIMEOUT, 16, max cycles waiting for mem_ready; 0 disables the watchdog
- CNTW, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  OPW  instruction opcode from IR; valid from DECODE onward
- zero  in  1  registered ALU zero flag, used by skip
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write when 1 (store only)
- mem_sel  out  1  0 instruction address (PC), 1 data address (ALU result)
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_src  out  2  0 PC+1, 1 jump target, 2/3 reserved
- reg_write  out  1  register file write enable
- reg_dst  out  1  1 destination from rd field, 0 from rt field
- wb_src  out  2  0 ALU result, 1 memory data, 2 constant zero
- alu_src  out  1  0 register, 1 immediate
- alu_op  out  ALUOPW  0 add (only encoding used)
- halted  out  1  core stopped
- illegal  out  1  sticky, undefined opcode trapped
- bus_err  out  1  sticky, memory timeout trapped
- retired  out  CNTW  completed-instruction count, saturating
- state  out  3  current state, debug

## Operation
- Opcodes: ADD 0, HALT 1, LOAD 2, STORE 3, CLEAR 4, SKIP 5, JUMP 6. All other values are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_sel=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE, by opcode:
  - ADD, LOAD, STORE: go to EXEC.
  - CLEAR: go to WB.
  - SKIP: if zero, pc_write=1 and pc_src=0 (skips next instruction). Go to FETCH.
  - JUMP: pc_write=1, pc_src=1, go to FETCH.
  - HALT: go to HALT.
  - Illegal: set illegal, go to HALT.
- EXEC: alu_op=0. ADD sets alu_src=0 and goes to WB. LOAD/STORE set alu_src=1 (address = base + imm) and go to MEM.
- MEM: mem_req=1, mem_sel=1, mem_we=STORE. On mem_ready: LOAD goes to WB, STORE goes to FETCH.
- WB: reg_write=1. ADD uses reg_dst=1, wb_src=0. LOAD uses reg_dst=0, wb_src=1. CLEAR uses reg_dst=1, wb_src=2. Then go to FETCH.
- HALT: halted=1, all enables 0. The state is absorbing; only reset exits.
- All enables and selects not listed for a state are 0. Outputs are Moore-decoded from state and opcode. ir_write, pc_write and the mem_ready-qualified actions are Mealy on mem_ready.
- Watchdog:
  - Counter clears on entering FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT (TIMEOUT>0): set bus_err, go to HALT, drop mem_req in the same cycle the transition takes effect.
- retired: increments by 1 on every transition into FETCH from a non-FETCH state, and on DECODE→HALT for a legal HALT. It does not increment on an illegal trap or a bus_err. It saturates at 2^CNTW−1.

## Timing
- Reset: the cycle after reset is high, state=FETCH, every output 0, retired=0, illegal=0, bus_err=0, watchdog=0. Reset mid-instruction aborts the instruction, and any in-flight memory request is dropped.
- mem_ready is ignored when mem_req=0. mem_req stays high, with address select stable, until the mem_ready cycle.
- Latency with zero-wait memory (mem_ready high on the first request cycle):
  - ADD: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - CLEAR: 3 cycles
  - SKIP, JUMP: 2 cycles
  - HALT: 2 cycles to halted=1
- Each memory wait cycle adds one cycle.
- If mem_ready arrives in the same cycle the watchdog reaches TIMEOUT, mem_ready wins: the request completes and there is no bus_err.

## Structure
- Package ctrl_pkg holds:
  - opcode constants;
  - state enum, 3-bit;
  - pc_src and wb_src encodings;
  - ALU op constants.
- One sub-module: ctrl_watchdog, a parametrised TIMEOUT counter with clear, count enable and an expired output.
- FSM and output decode stay in multicycle_ctrl.

## Test plan
- Reset, then ADD with mem_ready tied high: states FETCH→DECODE→EXEC→WB→FETCH. reg_write=1 only in WB with reg_dst=1, wb_src=0. retired=1 after 4 cycles.
- LOAD with 2 wait cycles on both the fetch and the data access: 9 cycles total. mem_sel=1 and mem_we=0 in MEM. WB has wb_src=1, reg_dst=0.
- STORE: mem_we=1 for exactly the MEM ready cycle window, no reg_write, 4 cycles with zero wait.
- SKIP with zero=1: pc_write pulses in FETCH and DECODE. With zero=0: one pulse only. JUMP: pc_src=1 in DECODE.
- Opcode 9: illegal=1, halted=1, retired unchanged. Remains halted for 20 cycles. Reset clears everything and FETCH restarts.
- TIMEOUT=4 and mem_ready held low in FETCH: bus_err=1 and HALT after 4 wait cycles. Repeat with mem_ready on cycle 4: no bus_err.
